// File: rtl/key_led_pkg.sv
// key_led_pkg: shared types and constants for the key/LED scheduler.
// Holds the FSM state type, pattern mode codes and the round-robin
// successor helper used by the arbiter.
package key_led_pkg;

  localparam int NUM_KEYS = 3;
  localparam int STEP_W   = 4;

  localparam logic [1:0] MODE_WALK  = 2'd0;
  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Next key index in round-robin order (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] next_key(input logic [1:0] k);
    logic [1:0] n;
    case (k)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_pattern_rom.sv
// led_pattern_rom: combinational LED pattern lookup from (mode, step).
// Walk = rotating single bit, blink = all-on/all-off, count = step value.
module led_pattern_rom
  import key_led_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  output logic [3:0]        pattern
);

  // Select the LED pattern for the requested mode and step.
  always_comb begin
    pattern = 4'b0000;
    case (mode)
      MODE_WALK:  pattern = 4'b0001 << step[1:0];
      MODE_BLINK: pattern = step[0] ? 4'b0000 : 4'b1111;
      MODE_COUNT: pattern = step[3:0];
      default:    pattern = 4'b0000;
    endcase
  end

endmodule

// File: rtl/key_led_sched.sv
// key_led_sched: round-robin scheduler sharing a 4-bit LED bank between
// three debounced keys. Each press queues one pattern run; a granted run
// lasts NUM_STEPS steps of STEP_CYCLES clocks each.
// Optional build macro KEY_LED_SCHED_CANCEL_EN: a press of the running
// key aborts the run instead of queuing a replay.
module key_led_sched
  import key_led_pkg::*;
#(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int NUM_STEPS   = 8,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_pulse,
  output logic [3:0] led_out,
  output logic       busy,
  output logic [1:0] grant_id,
  output logic [2:0] pending
);

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  state_t             state;
  logic [CNT_W-1:0]   tick;
  logic [STEP_W-1:0]  step;
  logic [1:0]         last_grant;

  logic [1:0]         win;
  logic [3:0]         pend_ext;
  logic [3:0]         pulse_ext;
  logic [1:0]         cand1;
  logic [1:0]         cand2;
  logic [1:0]         cand3;
  logic               tick_last;
  logic               step_last;
  logic               cancel_hit;
  logic [2:0]         set_mask;
  logic [2:0]         clear_mask;
  logic [1:0]         rom_mode;
  logic [STEP_W-1:0]  rom_step;
  logic [3:0]         rom_pattern;

  assign pend_ext  = {1'b0, pending};
  assign pulse_ext = {1'b0, key_pulse};
  assign tick_last = (tick == TICK_LAST);
  assign step_last = (step == STEP_LAST);

  // Round-robin pick: first pending key after the last granted one.
  always_comb begin
    cand1 = next_key(last_grant);
    cand2 = next_key(cand1);
    cand3 = next_key(cand2);
    if (pend_ext[cand1]) begin
      win = cand1;
    end else if (pend_ext[cand2]) begin
      win = cand2;
    end else begin
      win = cand3;
    end
  end

  // Cancel detection and request set/clear masks; set beats clear.
  always_comb begin
    set_mask   = key_pulse;
    cancel_hit = 1'b0;
`ifdef KEY_LED_SCHED_CANCEL_EN
    if ((state == RUN) && pulse_ext[grant_id]) begin
      cancel_hit = 1'b1;
      set_mask   = key_pulse & ~(3'b001 << grant_id);
    end else begin
      cancel_hit = 1'b0;
    end
`endif
    if ((state == IDLE) && (pending != 3'b000)) begin
      clear_mask = 3'b001 << win;
    end else begin
      clear_mask = 3'b000;
    end
  end

  // Pattern lookup: first step of the winner when granting, next step when running.
  always_comb begin
    if (state == IDLE) begin
      rom_mode = win;
      rom_step = 4'd0;
    end else begin
      rom_mode = grant_id;
      rom_step = step + 4'd1;
    end
  end

  led_pattern_rom u_rom (
    .mode    (rom_mode),
    .step    (rom_step),
    .pattern (rom_pattern)
  );

  // Request flags: clear on grant, set on press.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 3'b000;
    end else begin
      pending <= (pending & ~clear_mask) | set_mask;
    end
  end

  // Sequencer FSM with step/tick counters and registered LED outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      step       <= 4'd0;
      last_grant <= 2'd2;
      grant_id   <= 2'd0;
      led_out    <= 4'b0000;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending != 3'b000) begin
            state      <= RUN;
            grant_id   <= win;
            last_grant <= win;
            step       <= 4'd0;
            tick       <= '0;
            led_out    <= rom_pattern;
            busy       <= 1'b1;
          end else begin
            led_out  <= 4'b0000;
            busy     <= 1'b0;
            grant_id <= 2'd0;
          end
        end
        RUN: begin
          if (cancel_hit) begin
            state    <= IDLE;
            tick     <= '0;
            step     <= 4'd0;
            grant_id <= 2'd0;
            led_out  <= 4'b0000;
            busy     <= 1'b0;
          end else if (tick_last) begin
            tick <= '0;
            if (step_last) begin
              state    <= IDLE;
              step     <= 4'd0;
              grant_id <= 2'd0;
              led_out  <= 4'b0000;
              busy     <= 1'b0;
            end else begin
              step    <= step + 4'd1;
              led_out <= rom_pattern;
            end
          end else begin
            tick <= tick + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          tick     <= '0;
          step     <= 4'd0;
          grant_id <= 2'd0;
          led_out  <= 4'b0000;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
